// File: rtl/set_mode_sequencer_pkg.sv
// Shared mode encodings and mode-step function for set_mode_sequencer.
package set_mode_sequencer_pkg;

    localparam logic [2:0] MODE_RUN   = 3'b000;
    localparam logic [2:0] MODE_HOUR  = 3'b100;
    localparam logic [2:0] MODE_MIN   = 3'b101;
    localparam logic [2:0] MODE_DAY   = 3'b110;
    localparam logic [2:0] MODE_MONTH = 3'b111;
    localparam logic [2:0] MODE_YEAR  = 3'b011;

    function automatic logic [2:0] next_mode(input logic [2:0] mode);
        logic [2:0] nxt;
        case (mode)
            MODE_RUN:   nxt = MODE_HOUR;
            MODE_HOUR:  nxt = MODE_MIN;
            MODE_MIN:   nxt = MODE_DAY;
            MODE_DAY:   nxt = MODE_MONTH;
            MODE_MONTH: nxt = MODE_YEAR;
            default:    nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle press pulse
// registered together with the 0->1 change of the accepted level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/set_mode_sequencer.sv
// Button front-end for the clock/calendar: steps set modes on MODE, strobes b on INC.
// Optional auto-repeat of INC strobes is enabled by defining SETMODE_AUTOREPEAT_EN.
module set_mode_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_mode,
    input  logic btn_inc,
    output logic s2,
    output logic s1,
    output logic s0,
    output logic b,
    output logic setting
);
    import set_mode_sequencer_pkg::*;

    localparam int unsigned ToW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ToW-1:0] ToMax = ToW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic           mode_level, mode_press, inc_level, inc_press;
    logic [2:0]     mode_q, mode_d;
    logic           b_q, b_d;
    logic [ToW-1:0] to_q, to_d;
    logic           timeout_hit;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw_i (btn_mode),
        .level_o   (mode_level),
        .press_o   (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw_i (btn_inc),
        .level_o   (inc_level),
        .press_o   (inc_press)
    );

    logic unused_mode_level;
    assign unused_mode_level = mode_level;

`ifdef SETMODE_AUTOREPEAT_EN
    localparam int unsigned RepMaxCyc = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned RpW = (RepMaxCyc > 2) ? $clog2(RepMaxCyc) : 1;
    localparam logic [RpW-1:0] DelayMax  = RpW'(REPEAT_DELAY - 1);
    localparam logic [RpW-1:0] PeriodMax = RpW'(REPEAT_PERIOD - 1);

    logic           rep_act_q, rep_act_d;
    logic           rep_first_q, rep_first_d;
    logic [RpW-1:0] rep_cnt_q, rep_cnt_d;
`else
    localparam int unsigned unused_repeat = REPEAT_DELAY + REPEAT_PERIOD;
    logic unused_inc_level;
    assign unused_inc_level = inc_level;
`endif

    always_comb begin
        mode_d      = mode_q;
        b_d         = 1'b0;
        to_d        = to_q;
        timeout_hit = 1'b0;
        // MODE takes priority over a coincident INC press.
        if (mode_press) begin
            mode_d = next_mode(mode_q);
            to_d   = '0;
        end else if (mode_q != MODE_RUN) begin
            if (inc_press) begin
                b_d  = 1'b1;
                to_d = '0;
            end else if (TIMEOUT_CYCLES != 0) begin
                if (to_q == ToMax) begin
                    mode_d      = MODE_RUN;
                    to_d        = '0;
                    timeout_hit = 1'b1;
                end else begin
                    to_d = to_q + ToW'(1);
                end
            end
        end else begin
            to_d = '0;
        end
`ifdef SETMODE_AUTOREPEAT_EN
        rep_act_d   = rep_act_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        if (mode_press || timeout_hit || mode_q == MODE_RUN || !inc_level) begin
            rep_act_d = 1'b0;
            rep_cnt_d = '0;
        end else if (inc_press) begin
            rep_act_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
        end else if (rep_act_q) begin
            if (rep_cnt_q == (rep_first_q ? DelayMax : PeriodMax)) begin
                b_d         = 1'b1;
                rep_first_d = 1'b0;
                rep_cnt_d   = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + RpW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_RUN;
            b_q    <= 1'b0;
            to_q   <= '0;
        end else begin
            mode_q <= mode_d;
            b_q    <= b_d;
            to_q   <= to_d;
        end
    end

`ifdef SETMODE_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else begin
            rep_act_q   <= rep_act_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end
`endif

    assign {s2, s1, s0} = mode_q;
    assign b            = b_q;
    assign setting      = (mode_q != MODE_RUN);

endmodule

// File: doc/set_mode_sequencer.md
# set_mode_sequencer

Front-end sequencer that produces the mode-select code and field-increment strobe consumed by the clock/calendar counter control logic. It samples the two raw push-buttons (MODE, INC), synchronises and debounces them, steps through the set modes on each MODE press, and issues a one-cycle increment strobe per INC press (optionally auto-repeated) only while a set mode is active. It sits between the board buttons and the per-field counter-enable gates.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples required before a button level is accepted; at least 2.
- TIMEOUT_CYCLES, 500000000: idle cycles in a set mode before automatic return to RUN; 0 disables the timeout.
- REPEAT_DELAY, 50000000: cycles INC must be held before auto-repeat starts. Used only with auto-repeat.
- REPEAT_PERIOD, 10000000: cycles between auto-repeat strobes. Used only with auto-repeat.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_mode  in  1  raw MODE button, active-high, asynchronous, bouncy.
- btn_inc  in  1  raw INC button, active-high, asynchronous, bouncy.
- s2, s1, s0  out  1 each  mode code, MSB to LSB.
- b  out  1  increment strobe, one clk wide.
- setting  out  1  high in any mode other than RUN.

## Operation
- Reset is asynchronous and active-low. Assertion immediately forces the following values:
  - mode = RUN (000);
  - b = 0 and setting = 0;
  - synchronisers, debounce counters, timeout counter and repeat counter all cleared;
  - accepted button levels = 0.
- Each button passes through a 2-flop synchroniser and then a debouncer:
  - The counter counts consecutive synchronised samples that differ from the accepted level.
  - When the count reaches DEBOUNCE_CYCLES-1, the accepted level toggles and the counter clears.
  - Any sample equal to the accepted level clears the counter.
- A press event is a 0→1 transition of the accepted level. Releases generate no events.
- Mode state machine: RUN 000 → HOUR 100 → MIN 101 → DAY 110 → MONTH 111 → YEAR 011 → RUN 000.
  - The mode advances one step per MODE press event.
  - From YEAR, a MODE press wraps to RUN.
- An INC press event in any set mode produces b = 1 for exactly one cycle. In RUN, INC press events are discarded.
- If MODE and INC press events occur in the same cycle, the MODE event wins: the mode advances and no strobe is issued.
- Timeout:
  - The timeout counter is cleared by any press event and by every mode change.
  - In a set mode with TIMEOUT_CYCLES ≠ 0, reaching TIMEOUT_CYCLES-1 forces the mode to RUN.
  - The counter does not run in RUN.
- setting = (mode != RUN). It is derived combinationally from the registered mode bits.

## Timing
- The mode bits and b are registered outputs.
- Raw edge to output latency, with the raw input stable from the edge onward: accepted level changes DEBOUNCE_CYCLES+2 clk edges after the first sampling edge. b or the new mode appears on the following edge, giving a total of DEBOUNCE_CYCLES+3.
- b is never high on two consecutive cycles.
- The mode code changes at most once per cycle. It is never driven to 001 or 010.
- Reset asserted mid-press returns everything to reset values with no strobe. After release, a still-held button must be re-debounced; because the accepted level restarts at 0, the held button produces a press event.

## Configuration
- SETMODE_AUTOREPEAT_EN defined:
  - While INC is held (accepted level 1) in a set mode, an extra strobe is issued REPEAT_DELAY cycles after the initial strobe.
  - Further strobes follow every REPEAT_PERIOD cycles.
  - Release, a MODE event, the timeout or reset stops the repeat immediately.
- SETMODE_AUTOREPEAT_EN undefined: exactly one strobe per press. The repeat counter and REPEAT_* parameters are unused and their logic is absent.

## Structure
- Shared package holds:
  - mode encoding constants MODE_RUN, MODE_HOUR, MODE_MIN, MODE_DAY, MODE_MONTH, MODE_YEAR (3-bit);
  - the next-mode function.
- Sub-module btn_debounce (synchroniser + debounce counter + press-event output, parameter DEBOUNCE_CYCLES) is instantiated twice.
- The mode FSM, timeout and repeat logic stay in the top module.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset, then clean MODE press held for 10 cycles → mode 100 exactly 7 edges after the press, setting=1, b never asserted.
- MODE bounced 0/1 every cycle for 6 cycles, then held → single mode advance. Six clean presses from RUN → sequence 100, 101, 110, 111, 011, 000.
- INC press in RUN → b stays 0. INC press in 101 → one b pulse, 7 edges after the press.
- MODE and INC raw edges aligned in mode 100 → mode 101, b = 0 throughout.
- Enter 110 and stay idle 100 cycles → mode returns to 000 at cycle 100 after the last event. An INC press at cycle 50 → return to 000 is delayed to cycle 150.
- With SETMODE_AUTOREPEAT_EN, INC held 40 cycles in 100 → strobes at t0, t0+20, t0+25, t0+30, t0+35 and none after release. rst_n pulsed low mid-hold → b=0 and mode 000 immediately.
